// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: two-requester request/response bus plus the memory port.
// The arbiter connects through slave; requesters and the memory model use master.
interface data_mem_arbiter_if #(parameter int ADDR_W = 16, parameter int DATA_W = 32);
   logic              req0_valid, req0_ready, req0_we;
   logic              req1_valid, req1_ready, req1_we;
   logic [ADDR_W-1:0] req0_addr, req1_addr;
   logic [DATA_W-1:0] req0_wdata, req1_wdata;
   logic              rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
   logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              busy, owner;
   modport slave (
      input  req0_valid, req0_we, req0_addr, req0_wdata,
      input  req1_valid, req1_we, req1_addr, req1_wdata, mem_rdata,
      output req0_ready, req1_ready, rsp0_valid, rsp0_rdata, rsp0_err,
      output rsp1_valid, rsp1_rdata, rsp1_err,
      output mem_en, mem_we, mem_addr, mem_wdata, busy, owner
   );
   modport master (
      output req0_valid, req0_we, req0_addr, req0_wdata,
      output req1_valid, req1_we, req1_addr, req1_wdata, mem_rdata,
      input  req0_ready, req1_ready, rsp0_valid, rsp0_rdata, rsp0_err,
      input  rsp1_valid, rsp1_rdata, rsp1_err,
      input  mem_en, mem_we, mem_addr, mem_wdata, busy, owner
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-requester arbiter serialising single transactions onto one memory port.
// Synchronous active-low reset; every output is held at 0 while rst_n is low.
module data_mem_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int MEM_DEPTH  = 256,
   parameter int FIXED_PRIO = 0
) (
   input logic clk,
   input logic rst_n,
   data_mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t            state, state_nx;
   logic              last_grant, sel, acc, l_we, l_err, l_owner, rsp, issue;
   logic [ADDR_W-1:0] sel_addr, l_addr;
   logic [DATA_W-1:0] l_wdata, l_rdata, rdata;
   logic [2:0]        cnt;
   always_comb begin
      sel      = !bus.req0_valid ? 1'b1 : !bus.req1_valid ? 1'b0 : (FIXED_PRIO != 0) ? 1'b0 : !last_grant;
      acc      = rst_n && state == IDLE && (bus.req0_valid || bus.req1_valid);
      sel_addr = sel ? bus.req1_addr : bus.req0_addr;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         l_owner    <= 1'b0;
         l_we       <= 1'b0;
         l_err      <= 1'b0;
         l_addr     <= '0;
         l_wdata    <= '0;
         l_rdata    <= '0;
         cnt        <= '0;
      end else begin
         state <= state_nx;
         if (acc) begin
            last_grant <= sel;
            l_owner    <= sel;
            l_we       <= sel ? bus.req1_we : bus.req0_we;
            l_addr     <= sel_addr;
            l_wdata    <= sel ? bus.req1_wdata : bus.req0_wdata;
            l_err      <= {1'b0, sel_addr} >= (ADDR_W+1)'(MEM_DEPTH);
         end
         if (state == ISSUE) cnt <= 3'(MEM_LAT);
         else if (state == WAIT) cnt <= cnt - 3'd1;
         if (state == WAIT && cnt == 3'd1) l_rdata <= bus.mem_rdata;
      end
   end
   always_comb
      state_nx = state == IDLE  ? (acc ? ISSUE : IDLE) :
                 state == ISSUE ? ((l_we || l_err) ? RESP : WAIT) :
                 state == WAIT  ? (cnt == 3'd1 ? RESP : WAIT) : IDLE;
   always_comb begin
      issue          = rst_n && state == ISSUE;
      rsp            = rst_n && state == RESP;
      rdata          = (rsp && !l_we && !l_err) ? l_rdata : '0;
      bus.req0_ready = acc && !sel;
      bus.req1_ready = acc && sel;
      bus.busy       = rst_n && state != IDLE;
      bus.owner      = rst_n && l_owner;
      bus.mem_en     = issue && !l_err;
      bus.mem_we     = issue && !l_err && l_we;
      bus.mem_addr   = issue ? l_addr : '0;
      bus.mem_wdata  = issue ? l_wdata : '0;
      bus.rsp0_valid = rsp && !l_owner;
      bus.rsp1_valid = rsp && l_owner;
      bus.rsp0_rdata = l_owner ? '0 : rdata;
      bus.rsp1_rdata = l_owner ? rdata : '0;
      bus.rsp0_err   = rsp && !l_owner && l_err;
      bus.rsp1_err   = rsp && l_owner && l_err;
   end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: random traffic on five configurations (MEM_LAT 1..4 round-robin, fixed priority)
// compared against a transaction-timeline reference model.
module tb_data_mem_arbiter;
   localparam int NCYC = 1500;
   localparam int NCFG = 5;
   logic clk = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] init_word(input int a);
      return a == 5 ? 32'h1234_5678 : (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
   endfunction
   function automatic logic [15:0] pick_addr();
      case ($urandom_range(0, 6))
         0: return 16'h0000;
         1: return 16'h00FF;
         2: return 16'h0100;
         3: return 16'hFFFF;
         4: return 16'h0005;
         default: return 16'($urandom_range(0, 270));
      endcase
   endfunction
   for (genvar g = 0; g < NCFG; g++) begin : cfg
      localparam int LAT = g < 4 ? g + 1 : 2;
      localparam int FP  = g == 4 ? 1 : 0;
      logic        rst_n;
      logic [31:0] mem_dev [256];
      bit          written [256];
      logic [31:0] rd_word;
      int          rd_cnt = 0;
      data_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();
      data_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(LAT), .MEM_DEPTH(256), .FIXED_PRIO(FP))
         dut (.clk(clk), .rst_n(rst_n), .bus(bus));
      // Memory device: read data is only valid during the cycle the arbiter must capture it.
      assign bus.mem_rdata = rd_cnt == 1 ? rd_word : (32'hBAD0_0000 | 32'(g));
      always @(posedge clk) begin
         if (bus.mem_en && bus.mem_we) begin
            mem_dev[bus.mem_addr[7:0]] <= bus.mem_wdata;
            written[bus.mem_addr[7:0]] <= 1'b1;
         end
         if (bus.mem_en && !bus.mem_we) begin
            rd_cnt  <= LAT;
            rd_word <= written[bus.mem_addr[7:0]] ? mem_dev[bus.mem_addr[7:0]] : init_word(int'(bus.mem_addr[7:0]));
         end else if (rd_cnt != 0) rd_cnt <= rd_cnt - 1;
      end
      initial begin
         logic [31:0] mem_ref [256];
         bit          rv [2], rwe [2];
         logic [15:0] ra [2];
         logic [31:0] rd [2];
         bit          have, q_we, q_err, q_own, last_grant, did_mid, rst_c, acc, sel, issue, pulse;
         logic [15:0] q_addr;
         logic [31:0] q_wdata, q_rdata;
         int          t_acc, t_rsp;
         string       p;
         p = $sformatf("cfg%0d ", g);
         for (int i = 0; i < 256; i++) mem_ref[i] = init_word(i);
         for (int n = 0; n < 2; n++) begin
            rv[n] = 0; rwe[n] = 0; ra[n] = '0; rd[n] = '0;
         end
         have = 0; last_grant = 1; did_mid = 0; t_acc = 0; t_rsp = 0;
         q_we = 0; q_err = 0; q_own = 0; q_addr = '0; q_wdata = '0; q_rdata = '0;
         rst_n = 1'b0;
         bus.req0_valid = 0; bus.req0_we = 0; bus.req0_addr = '0; bus.req0_wdata = '0;
         bus.req1_valid = 0; bus.req1_we = 0; bus.req1_addr = '0; bus.req1_wdata = '0;
         repeat (3) @(posedge clk);
         for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            rst_c = c < 2 || $urandom_range(0, 199) == 0 ||
                    (!did_mid && c > 20 && have && !q_we && !q_err && c == t_acc + 2);
            if (!did_mid && c > 20 && have && !q_we && !q_err && c == t_acc + 2) did_mid = 1;
            for (int n = 0; n < 2; n++) begin
               if (rv[n] && $urandom_range(0, 15) == 0) rv[n] = 0;
               else if (!rv[n]) begin
                  rv[n]  = $urandom_range(0, 2) != 0;
                  rwe[n] = $urandom_range(0, 2) == 0;
                  ra[n]  = pick_addr();
                  rd[n]  = $urandom;
               end
            end
            rst_n = !rst_c;
            bus.req0_valid = rv[0]; bus.req0_we = rwe[0]; bus.req0_addr = ra[0]; bus.req0_wdata = rd[0];
            bus.req1_valid = rv[1]; bus.req1_we = rwe[1]; bus.req1_addr = ra[1]; bus.req1_wdata = rd[1];
            #1;
            if (have && c > t_rsp) have = 0;
            if (rst_c) begin
               check({p, "rst ready0"}, bus.req0_ready, 0);
               check({p, "rst ready1"}, bus.req1_ready, 0);
               check({p, "rst busy"}, bus.busy, 0);
               check({p, "rst owner"}, bus.owner, 0);
               check({p, "rst mem_en"}, bus.mem_en, 0);
               check({p, "rst mem_we"}, bus.mem_we, 0);
               check({p, "rst rsp0"}, {bus.rsp0_valid, bus.rsp0_err}, 0);
               check({p, "rst rsp1"}, {bus.rsp1_valid, bus.rsp1_err}, 0);
               have = 0;
               last_grant = 1;
            end else begin
               acc = !have && (rv[0] || rv[1]);
               if (rv[0] && rv[1]) sel = FP ? 1'b0 : !last_grant;
               else sel = rv[1];
               issue = have && c == t_acc + 1;
               pulse = have && c == t_rsp;
               check({p, "ready0"}, bus.req0_ready, acc && !sel);
               check({p, "ready1"}, bus.req1_ready, acc && sel);
               check({p, "busy"}, bus.busy, have && c > t_acc);
               check({p, "mem_en"}, bus.mem_en, issue && !q_err);
               check({p, "mem_we"}, bus.mem_we, issue && !q_err && q_we);
               check({p, "rsp0_valid"}, bus.rsp0_valid, pulse && !q_own);
               check({p, "rsp1_valid"}, bus.rsp1_valid, pulse && q_own);
               if (have && c > t_acc) check({p, "owner"}, bus.owner, q_own);
               if (issue) check({p, "mem_addr"}, bus.mem_addr, q_addr);
               if (issue && q_we) check({p, "mem_wdata"}, bus.mem_wdata, q_wdata);
               if (pulse) begin
                  check({p, "rsp_rdata"}, q_own ? bus.rsp1_rdata : bus.rsp0_rdata, q_rdata);
                  check({p, "rsp_err"}, q_own ? bus.rsp1_err : bus.rsp0_err, q_err);
               end
               if (issue && q_we && !q_err) mem_ref[q_addr[7:0]] = q_wdata;
               if (acc) begin
                  have    = 1;
                  t_acc   = c;
                  q_own   = sel;
                  q_we    = rwe[sel];
                  q_addr  = ra[sel];
                  q_wdata = rd[sel];
                  q_err   = ra[sel] >= 16'd256;
                  t_rsp   = c + 2 + ((!q_we && !q_err) ? LAT : 0);
                  q_rdata = (q_we || q_err) ? 32'h0 : mem_ref[q_addr[7:0]];
                  last_grant = sel;
                  rv[sel] = 0;
               end
            end
         end
         done_cnt++;
      end
   end
   initial begin
      for (int i = 0; i < 20000 && done_cnt < NCFG; i++) @(posedge clk);
      check("all_cfg_done", done_cnt, NCFG);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
